// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_pkg                                                          |
// | Brief   : Opcode/state encodings and opcode classifiers for alu_seq_md.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLT   = 4'd5,
      OP_SLL   = 4'd6,
      OP_SRL   = 4'd7,
      OP_SRA   = 4'd8,
      OP_SLTU  = 4'd9,
      OP_MUL   = 4'd10,
      OP_MULHU = 4'd11,
      OP_DIV   = 4'd12,
      OP_DIVU  = 4'd13,
      OP_REM   = 4'd14,
      OP_REMU  = 4'd15
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SIMPLE = 3'd1,
      ST_MUL    = 3'd2,
      ST_DIV    = 3'd3,
      ST_DONE   = 3'd4
   } alu_state_e;

   function automatic logic is_signed_md(input alu_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_mul_op(input alu_op_e op);
      return (op == OP_MUL) || (op == OP_MULHU);
   endfunction

   function automatic logic is_div_op(input alu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_md_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_seq_md_if                                                    |
// | Brief   : Request/response handshake bundle between pipeline and ALU.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface alu_seq_md_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alucontrol;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;

   modport master (
      output in_valid, a, b, alucontrol, out_ready,
      input  in_ready, out_valid, result, zero, overflow
   );

   modport slave (
      input  in_valid, a, b, alucontrol, out_ready,
      output in_ready, out_valid, result, zero, overflow
   );
endinterface
`default_nettype wire

// File: rtl/alu_md_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_md_iter                                                      |
// | Brief   : Shared bit-serial unsigned shift-add multiplier / restoring      |
// |           divider; one bit per cycle, WIDTH cycles per operation.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_md_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi
);

   localparam int c_CNT_W = $clog2(WIDTH);

   logic [c_CNT_W-1:0] r_cnt;
   logic               r_busy;
   logic               r_done;
   logic               r_is_div;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_m;

   logic [WIDTH:0]     w_madd;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH-1:0]   w_diff;
   logic               w_ge;
   logic [WIDTH-1:0]   w_hi_nxt;
   logic [WIDTH-1:0]   w_lo_nxt;

   // {r_hi,r_lo} is the product for multiply and {remainder,quotient} for divide.
   // When w_ge holds the true difference is below r_m, so the W-bit subtract is exact.
   always_comb begin
      w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      w_shift = {r_hi, r_lo[WIDTH-1]};
      w_ge    = (w_shift >= {1'b0, r_m});
      w_diff  = w_shift[WIDTH-1:0] - r_m;
      if (r_is_div) begin
         w_hi_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
         w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
      end else begin
         w_hi_nxt = w_madd[WIDTH:1];
         w_lo_nxt = {w_madd[0], r_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_is_div <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_m      <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_hi     <= '0;
            r_lo     <= i_a;
            r_m      <= i_b;
            r_is_div <= i_is_div;
            r_cnt    <= c_CNT_W'(WIDTH - 1);
            r_busy   <= 1'b1;
         end else if (r_busy) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == '0) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

   assign o_done = r_done;
   assign o_lo   = r_lo;
   assign o_hi   = r_hi;

endmodule
`default_nettype wire

// File: rtl/alu_seq_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_seq_md                                                       |
// | Brief   : Handshaked integer ALU with iterative multiply/divide; one       |
// |           operation in flight, result held until accepted.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_seq_md
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        reset_n,
   alu_seq_md_if.slave if_alu
);

   localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
   localparam logic [WIDTH-1:0] c_SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

   alu_state_e       r_state;
   alu_state_e       w_state_nxt;
   alu_op_e          r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_out_valid;

   logic             w_accept;
   logic             w_start;
   logic             w_load;
   logic [WIDTH-1:0] w_res_nxt;
   logic             w_ovf_nxt;

   // Request-side decode on live operands, used only on the accept cycle.
   alu_op_e          w_in_op;
   logic             w_in_special;
   logic             w_in_iter;
   logic             w_in_sgn;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;

   logic             w_iter_done;
   logic [WIDTH-1:0] w_iter_lo;
   logic [WIDTH-1:0] w_iter_hi;

   logic             w_inv_b;
   logic [WIDTH-1:0] w_b_op;
   logic [WIDTH-1:0] w_sum;
   logic             w_sum_ovf;
   logic [SHAMT_W-1:0] w_shamt;
   logic [WIDTH-1:0] w_simple_res;
   logic             w_simple_ovf;
   logic [WIDTH-1:0] w_md_res;

   // Divide-by-zero and MIN/-1 bypass the iterator and resolve in one cycle.
   always_comb begin
      w_in_op      = alu_op_e'(if_alu.alucontrol);
      w_in_sgn     = is_signed_md(w_in_op);
      w_in_special = is_div_op(w_in_op) &&
                     ((if_alu.b == '0) ||
                      (w_in_sgn && (if_alu.a == c_SMIN) && (if_alu.b == c_ALL_ONES)));
      w_in_iter    = (is_mul_op(w_in_op) || is_div_op(w_in_op)) && !w_in_special;
      w_a_mag      = (w_in_sgn && if_alu.a[WIDTH-1]) ? -if_alu.a : if_alu.a;
      w_b_mag      = (w_in_sgn && if_alu.b[WIDTH-1]) ? -if_alu.b : if_alu.b;
   end

   alu_md_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_start  (w_start),
      .i_is_div (!is_mul_op(w_in_op)),
      .i_a      (w_a_mag),
      .i_b      (w_b_mag),
      .o_done   (w_iter_done),
      .o_lo     (w_iter_lo),
      .o_hi     (w_iter_hi)
   );

   always_comb begin
      w_inv_b   = (r_op == OP_SUB) || (r_op == OP_SLT);
      w_b_op    = w_inv_b ? ~r_b : r_b;
      w_sum     = r_a + w_b_op + {{(WIDTH-1){1'b0}}, w_inv_b};
      w_sum_ovf = (r_a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      w_shamt   = r_b[SHAMT_W-1:0];

      w_simple_res = '0;
      w_simple_ovf = 1'b0;
      case (r_op)
         OP_ADD, OP_SUB: begin
            w_simple_res = w_sum;
            w_simple_ovf = w_sum_ovf;
         end
         OP_AND:  w_simple_res = r_a & r_b;
         OP_OR:   w_simple_res = r_a | r_b;
         OP_XOR:  w_simple_res = r_a ^ r_b;
         OP_SLT:  w_simple_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_sum_ovf};
         OP_SLL:  w_simple_res = r_a << w_shamt;
         OP_SRL:  w_simple_res = r_a >> w_shamt;
         OP_SRA:  w_simple_res = WIDTH'($signed(r_a) >>> w_shamt);
         OP_SLTU: w_simple_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
         // Only the special cases reach here: b==0, or signed MIN / -1.
         OP_DIV, OP_DIVU: w_simple_res = (r_b == '0) ? c_ALL_ONES : r_a;
         OP_REM, OP_REMU: w_simple_res = (r_b == '0) ? r_a : '0;
         default: w_simple_res = '0;
      endcase

      w_md_res = '0;
      case (r_op)
         OP_MUL:          w_md_res = w_iter_lo;
         OP_MULHU:        w_md_res = w_iter_hi;
         OP_DIV, OP_DIVU: w_md_res = (is_signed_md(r_op) && (r_a[WIDTH-1] ^ r_b[WIDTH-1]))
                                     ? -w_iter_lo : w_iter_lo;
         OP_REM, OP_REMU: w_md_res = (is_signed_md(r_op) && r_a[WIDTH-1])
                                     ? -w_iter_hi : w_iter_hi;
         default:         w_md_res = '0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_res_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (if_alu.in_valid) begin
               w_accept = 1'b1;
               if (w_in_iter) begin
                  w_start     = 1'b1;
                  w_state_nxt = is_mul_op(w_in_op) ? ST_MUL : ST_DIV;
               end else begin
                  w_state_nxt = ST_SIMPLE;
               end
            end
         end
         ST_SIMPLE: begin
            w_load      = 1'b1;
            w_res_nxt   = w_simple_res;
            w_ovf_nxt   = w_simple_ovf;
            w_state_nxt = ST_DONE;
         end
         ST_MUL, ST_DIV: begin
            if (w_iter_done) begin
               w_load      = 1'b1;
               w_res_nxt   = w_md_res;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (if_alu.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_op        <= OP_ADD;
         r_a         <= '0;
         r_b         <= '0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op <= w_in_op;
            r_a  <= if_alu.a;
            r_b  <= if_alu.b;
         end
         if (w_load) begin
            r_result    <= w_res_nxt;
            r_zero      <= (w_res_nxt == '0);
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= 1'b1;
         end else if ((r_state == ST_DONE) && if_alu.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign if_alu.in_ready  = (r_state == ST_IDLE);
   assign if_alu.out_valid = r_out_valid;
   assign if_alu.result    = r_result;
   assign if_alu.zero      = r_zero;
   assign if_alu.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_seq_md                                                    |
// | Brief   : Vector-table and scoreboard bench for alu_seq_md (WIDTH=32).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_seq_md;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic        z;
      logic        ovf;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_tests;
   int   n_fail;
   vec_t vecs[$];
   vec_t sb[$];

   alu_seq_md_if #(.WIDTH(32)) bus ();

   alu_seq_md #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .if_alu  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic addv(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] res, input logic z, input logic ovf, input int lat);
      vec_t v;
      v.a = a; v.b = b; v.op = op; v.res = res; v.z = z; v.ovf = ovf; v.lat = lat;
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] model_md(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
      logic [63:0] p;
      logic [31:0] r;
      p = {32'b0, a} * {32'b0, b};
      case (op)
         4'd10:   r = p[31:0];
         4'd11:   r = p[63:32];
         4'd12:   r = $signed(a) / $signed(b);
         4'd13:   r = a / b;
         4'd14:   r = $signed(a) % $signed(b);
         default: r = a % b;
      endcase
      return r;
   endfunction

   // Waits for in_ready, presents one request and releases it after the accept edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      int guard;
      guard = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (bus.in_ready !== 1'b1) chk("in_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
      bus.a          = a;
      bus.b          = b;
      bus.alucontrol = op;
      bus.in_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid   = 1'b0;
      bus.a          = $urandom;
      bus.b          = $urandom;
      bus.alucontrol = 4'($urandom_range(0, 15));
   endtask

   task automatic collect(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic score(input string tag, input int lat);
      vec_t e;
      if (bus.out_valid !== 1'b1) begin
         chk({tag, "_out_valid_timeout"}, {31'b0, bus.out_valid}, 32'd1);
      end else if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_res"}, bus.result, e.res);
         chk({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, e.z});
         chk({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, e.ovf});
         chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      issue(v.a, v.b, v.op);
      sb.push_back(v);
      collect(lat);
      score(tag, lat);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   lat;
      n_tests        = 0;
      n_fail         = 0;
      bus.in_valid   = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.alucontrol = '0;
      bus.out_ready  = 1'b1;
      reset_n        = 1'b0;

      //      a             b             op     result        z     ovf   lat
      addv(32'd5,        32'd7,        4'd0,  32'd12,       1'b0, 1'b0, 1);
      addv(32'h7FFFFFFF, 32'd1,        4'd0,  32'h80000000, 1'b0, 1'b1, 1);
      addv(32'h80000000, 32'd1,        4'd1,  32'h7FFFFFFF, 1'b0, 1'b1, 1);
      addv(32'd5,        32'd5,        4'd1,  32'd0,        1'b1, 1'b0, 1);
      addv(32'hF0F0F0F0, 32'hFF00FF00, 4'd2,  32'hF000F000, 1'b0, 1'b0, 1);
      addv(32'hF0F0F0F0, 32'h0F0F0000, 4'd3,  32'hFFFFF0F0, 1'b0, 1'b0, 1);
      addv(32'hAAAA5555, 32'hFFFF0000, 4'd4,  32'h55555555, 1'b0, 1'b0, 1);
      addv(32'hFFFFFFFF, 32'd1,        4'd5,  32'd1,        1'b0, 1'b0, 1);
      addv(32'h80000000, 32'd1,        4'd5,  32'd1,        1'b0, 1'b0, 1);
      addv(32'd1,        32'h0000003F, 4'd6,  32'h80000000, 1'b0, 1'b0, 1);
      addv(32'h80000000, 32'd4,        4'd7,  32'h08000000, 1'b0, 1'b0, 1);
      addv(32'h80000000, 32'd4,        4'd8,  32'hF8000000, 1'b0, 1'b0, 1);
      addv(32'd1,        32'hFFFFFFFF, 4'd9,  32'd1,        1'b0, 1'b0, 1);
      addv(32'hFFFFFFFF, 32'd1,        4'd9,  32'd0,        1'b1, 1'b0, 1);
      addv(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd10, 32'h00000001, 1'b0, 1'b0, 33);
      addv(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd11, 32'hFFFFFFFE, 1'b0, 1'b0, 33);
      addv(32'd3,        32'd5,        4'd10, 32'd15,       1'b0, 1'b0, 33);
      addv(32'hFFFFFFF9, 32'd2,        4'd12, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
      addv(32'hFFFFFFF9, 32'd2,        4'd14, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
      addv(32'd7,        32'd0,        4'd13, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
      addv(32'd7,        32'd0,        4'd15, 32'd7,        1'b0, 1'b0, 1);
      addv(32'h80000000, 32'hFFFFFFFF, 4'd12, 32'h80000000, 1'b0, 1'b0, 1);
      addv(32'h80000000, 32'hFFFFFFFF, 4'd14, 32'd0,        1'b1, 1'b0, 1);
      addv(32'd100,      32'd7,        4'd13, 32'd14,       1'b0, 1'b0, 33);
      addv(32'd100,      32'd7,        4'd15, 32'd2,        1'b0, 1'b0, 33);
      addv(32'd7,        32'hFFFFFFFE, 4'd12, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
      addv(32'd7,        32'hFFFFFFFE, 4'd14, 32'd1,        1'b0, 1'b0, 33);
      addv(32'd0,        32'd5,        4'd12, 32'd0,        1'b1, 1'b0, 33);
      addv(32'h80000000, 32'd4,        4'd11, 32'd2,        1'b0, 1'b0, 33);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_zero", {31'b0, bus.zero}, 32'd0);
      chk("rst_ovf", {31'b0, bus.overflow}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      for (int i = 0; i < 8; i++) begin
         v.a  = $urandom;
         v.b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (v.b == 32'd0)          v.b = 32'd1;
         if (v.b == 32'hFFFFFFFF)   v.b = 32'd3;
         v.op  = 4'(10 + $urandom_range(0, 5));
         v.res = model_md(v.a, v.b, v.op);
         v.z   = (v.res == 32'd0);
         v.ovf = 1'b0;
         v.lat = 33;
         run_vec(v, $sformatf("rnd%0d", i));
      end

      // Reset ten cycles into a divide aborts it.
      issue(32'd1000, 32'd3, 4'd12);
      repeat (9) @(posedge clk);
      #1;
      chk("abort_busy_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("abort_busy_in_ready", {31'b0, bus.in_ready}, 32'd0);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("abort_result", bus.result, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_late_valid", {31'b0, bus.out_valid}, 32'd0);

      // Back-pressure: result held for five cycles while extra requests are ignored.
      bus.out_ready = 1'b0;
      v.a = 32'd1; v.b = 32'd2; v.op = 4'd0; v.res = 32'd3; v.z = 1'b0; v.ovf = 1'b0; v.lat = 1;
      issue(v.a, v.b, v.op);
      sb.push_back(v);
      collect(lat);
      score("hold", lat);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.in_valid   = 1'b1;
         bus.a          = 32'd9;
         bus.b          = 32'd9;
         bus.alucontrol = 4'd0;
         @(posedge clk);
         #1;
         chk($sformatf("hold%0d_result", k), bus.result, 32'd3);
         chk($sformatf("hold%0d_out_valid", k), {31'b0, bus.out_valid}, 32'd1);
         chk($sformatf("hold%0d_in_ready", k), {31'b0, bus.in_ready}, 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_out_valid_drop", {31'b0, bus.out_valid}, 32'd0);
      chk("hs_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("hs_no_stray_result", {31'b0, bus.out_valid}, 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
